// File: rtl/regfile_wr_arbiter_if.sv
// ============================================================================
// regfile_wr_arbiter_if : requester handshakes and RF write-port bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface regfile_wr_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 32,
    parameter int CW = 16
);
    logic          v0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          r0;
    logic          v1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          r1;
    logic          rf_we;
    logic [AW-1:0] rf_wn;
    logic [DW-1:0] rf_d;
    logic [CW-1:0] wr_cnt;

    modport master (
        output v0, a0, d0, v1, a1, d1,
        input  r0, r1, rf_we, rf_wn, rf_d, wr_cnt
    );

    modport slave (
        input  v0, a0, d0, v1, a1, d1,
        output r0, r1, rf_we, rf_wn, rf_d, wr_cnt
    );
endinterface

`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
// ============================================================================
// regfile_wr_arbiter : round-robin arbiter for the single RF write port, with
// same-address ordering and optional write bypass (RFARB_BYPASS_EN). Rev 1.0
// ============================================================================
`default_nettype none

module regfile_wr_arbiter #(
    parameter int AW = 5,
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  wire logic            clk_i,
    input  wire logic            rst_ni,
    input  wire logic            flush_i,
    regfile_wr_arbiter_if.slave  bus
`ifdef RFARB_BYPASS_EN
    ,
    input  wire logic [AW-1:0]   byp_rn_i,
    output logic                 byp_hit_o,
    output logic [DW-1:0]        byp_d_o
`endif
);

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_COLL   = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic          prio_q, prio_d;
    logic          we_q, we_d;
    logic [AW-1:0] wn_q, wn_d;
    logic [DW-1:0] wd_q, wd_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          w_run;
    logic          w_same;
    logic          w_gnt0;
    logic          w_gnt1;

    assign w_run  = rst_ni & ~flush_i;
    assign w_same = (bus.a0 == bus.a1);

    always_comb begin
        w_gnt0  = 1'b0;
        w_gnt1  = 1'b0;
        prio_d  = prio_q;
        state_d = state_q;
        if (w_run) begin
            state_d = ST_NORMAL;
            // Second half of a same-address pair: the younger Req0 value lands last.
            if (state_q == ST_COLL && bus.v0) begin
                w_gnt0 = 1'b1;
            end else if (bus.v0 && bus.v1) begin
                if (w_same) begin
                    w_gnt1  = 1'b1;
                    state_d = ST_COLL;
                end else if (prio_q) begin
                    w_gnt1 = 1'b1;
                    prio_d = 1'b0;
                end else begin
                    w_gnt0 = 1'b1;
                    prio_d = 1'b1;
                end
            end else if (bus.v0) begin
                w_gnt0 = 1'b1;
            end else if (bus.v1) begin
                w_gnt1 = 1'b1;
            end
        end
    end

    always_comb begin
        we_d  = 1'b0;
        wn_d  = wn_q;
        wd_d  = wd_q;
        if (w_gnt1) begin
            wn_d = bus.a1;
            wd_d = bus.d1;
            we_d = (bus.a1 != '0);
        end else if (w_gnt0) begin
            wn_d = bus.a0;
            wd_d = bus.d0;
            we_d = (bus.a0 != '0);
        end
        // Counted together with staging so the count includes the pulse on show.
        cnt_d = cnt_q + {{(CW-1){1'b0}}, we_d};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_NORMAL;
            prio_q  <= 1'b0;
            we_q    <= 1'b0;
            wn_q    <= '0;
            wd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            we_q    <= we_d;
            wn_q    <= wn_d;
            wd_q    <= wd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.r0     = w_gnt0;
    assign bus.r1     = w_gnt1;
    assign bus.rf_we  = we_q;
    assign bus.rf_wn  = wn_q;
    assign bus.rf_d   = wd_q;
    assign bus.wr_cnt = cnt_q;

`ifdef RFARB_BYPASS_EN
    assign byp_hit_o = we_q & (wn_q == byp_rn_i) & (byp_rn_i != '0);
    assign byp_d_o   = byp_hit_o ? wd_q : '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
// ============================================================================
// tb_regfile_wr_arbiter : directed stimulus with queued expected writes
// checked by an independent monitor. Rev 1.0
// ============================================================================
`default_nettype none

module tb_regfile_wr_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int CW = 16;

    typedef struct packed {
        logic [AW-1:0] wn;
        logic [DW-1:0] d;
    } wr_t;

    logic clk;
    logic rst_n;
    logic flush;

    regfile_wr_arbiter_if #(.AW(AW), .DW(DW), .CW(CW)) bus ();

`ifdef RFARB_BYPASS_EN
    logic [AW-1:0] byp_rn;
    logic          byp_hit;
    logic [DW-1:0] byp_d;
`endif

    regfile_wr_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .flush_i  (flush),
        .bus      (bus)
`ifdef RFARB_BYPASS_EN
        ,
        .byp_rn_i (byp_rn),
        .byp_hit_o(byp_hit),
        .byp_d_o  (byp_d)
`endif
    );

    int            n_pass = 0;
    int            n_tot  = 0;
    wr_t           exp_q[$];
    logic [CW-1:0] exp_cnt = '0;
    logic [CW-1:0] n_push  = '0;
    logic [DW-1:0] regs [2**AW];
    logic          mon_en  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic step(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input logic fl, input logic er0, input logic er1);
        bus.v0 = v0; bus.a0 = a0; bus.d0 = d0;
        bus.v1 = v1; bus.a1 = a1; bus.d1 = d1;
        flush  = fl;
        @(negedge clk);
        chk("grant_r0", bus.r0, er0);
        chk("grant_r1", bus.r1, er1);
        if (er0 && a0 != '0) begin exp_q.push_back('{wn: a0, d: d0}); n_push++; end
        if (er1 && a1 != '0) begin exp_q.push_back('{wn: a1, d: d1}); n_push++; end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: every RF write pulse must match the oldest expected write.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (mon_en && rst_n) begin
            if (bus.rf_we) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_we", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    exp_cnt = exp_cnt + 1'b1;
                    chk("rf_wn", bus.rf_wn, e.wn);
                    chk("rf_d", bus.rf_d, e.d);
                    chk("wr_cnt", bus.wr_cnt, exp_cnt);
                    regs[bus.rf_wn] = bus.rf_d;
`ifdef RFARB_BYPASS_EN
                    chk("byp_hit", byp_hit, (e.wn == byp_rn));
                    chk("byp_d", byp_d, (e.wn == byp_rn) ? e.d : '0);
`endif
                end
            end
`ifdef RFARB_BYPASS_EN
            else begin
                chk("byp_idle", byp_hit, 1'b0);
            end
`endif
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        for (int i = 0; i < 2**AW; i++) regs[i] = '0;
`ifdef RFARB_BYPASS_EN
        byp_rn = 5'd5;
`endif
        rst_n  = 1'b0;
        flush  = 1'b0;
        bus.v0 = 1'b1; bus.a0 = 5'd3; bus.d0 = 32'hA0;
        bus.v1 = 1'b1; bus.a1 = 5'd7; bus.d1 = 32'hB0;

        // Reset holds grants low even with both requesters valid.
        @(negedge clk);
        @(negedge clk);
        chk("rst_r0", bus.r0, 1'b0);
        chk("rst_r1", bus.r1, 1'b0);
        chk("rst_we", bus.rf_we, 1'b0);
        chk("rst_cnt", bus.wr_cnt, '0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Round-robin with distinct addresses, starting at Req0.
        for (int k = 0; k < 4; k++)
            step(1'b1, 5'd3, 32'hA0 + (k + 1) / 2, 1'b1, 5'd7, 32'hB0 + k / 2,
                 1'b0, (k % 2) == 0, (k % 2) == 1);

        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        idle();

        // Same-address collision: Req1 first, then Req0.
        step(1'b1, 5'd9, 32'd1, 1'b1, 5'd9, 32'd2, 1'b0, 1'b0, 1'b1);
        step(1'b1, 5'd9, 32'd1, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        idle();
        idle();
        chk("reg9_final", regs[9], 32'd1);

        // Address 0 is granted but never written.
        step(1'b1, 5'd0, 32'h55, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        idle();
        chk("zero_cnt", bus.wr_cnt, exp_cnt);

        // A pulse already on show completes during flush; nothing is granted.
        step(1'b1, 5'd6, 32'h66, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 5'd4, 32'h44, 1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd3, 32'hC3, 1'b1, 5'd7, 32'hC7, 1'b1, 1'b0, 1'b0);
        idle();
        chk("flush_cnt", bus.wr_cnt, exp_cnt);

        // Priority survived the flush.
        step(1'b1, 5'd3, 32'hC3, 1'b1, 5'd7, 32'hC7, 1'b0, 1'b1, 1'b0);
        step(1'b1, 5'd3, 32'hC4, 1'b1, 5'd7, 32'hC7, 1'b0, 1'b0, 1'b1);
        idle();

        // Fill the counter to all-ones, then one more write wraps it.
        while (n_push != {CW{1'b1}})
            step(1'b1, 5'd5, {16'h0, n_push}, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 5'd5, 32'hF00D, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        idle();
        idle();
        chk("wrap_cnt", bus.wr_cnt, '0);
        chk("drain", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

`default_nettype wire
